// File: rtl/fetch_pc_unit_if.sv
// Purpose: bundles the redirect, imem request/response and decode-side handshake of fetch_pc_unit.
// Latency: wires only.
// Backpressure: imem_req_ready stalls requests; instr_ready stalls delivery; responses cannot be stalled.
// Ports: redirect_valid/address in; imem_req_valid/ready/address; imem_resp_valid/data in;
//        instr_valid/ready/data/pc out. master = fetch unit, slave = imem + decode + redirect source.
interface fetch_pc_unit_if #(
    parameter int XLEN = 64,
    parameter int ILEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_address;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_address;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr_data;
    logic [XLEN-1:0] instr_pc;

    modport master (
        input  redirect_valid, redirect_address,
        output imem_req_valid, imem_req_address,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output instr_valid, instr_data, instr_pc,
        input  instr_ready
    );

    modport slave (
        output redirect_valid, redirect_address,
        input  imem_req_valid, imem_req_address,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  instr_valid, instr_data, instr_pc,
        output instr_ready
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// Purpose: owns the PC, issues in-order imem fetches, buffers {instr, pc} for decode; redirect reloads and flushes.
// Latency: request accepted cycle N, response cycle N+k -> instr_valid from cycle N+k+1.
// Backpressure: requests limited by credits (outstanding + buffered < BUF_DEPTH); decode stalls via instr_ready.
// Ports: clk, rst_n (async active-low), bus (fetch_pc_unit_if.master).
module fetch_pc_unit #(
    parameter int              XLEN         = 64,
    parameter int              ILEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BUF_DEPTH    = 2
) (
    input logic             clk,
    input logic             rst_n,
    fetch_pc_unit_if.master bus
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int PW = $clog2(BUF_DEPTH);
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(BUF_DEPTH);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic            req_vld_q, req_vld_d;
    logic [ILEN-1:0] buf_dat_q [BUF_DEPTH];
    logic [XLEN-1:0] buf_pc_q  [BUF_DEPTH];

    logic            req_fire, resp_fire, pop, push, buf_vld;
    logic [XLEN-1:0] redir_pc;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = ^bus.redirect_address[1:0];
    assign redir_pc  = {bus.redirect_address[XLEN-1:2], 2'b00};
    assign buf_vld   = (count_q != '0);
    assign req_fire  = req_vld_q & bus.imem_req_ready;
    // Stray responses with nothing outstanding are ignored.
    assign resp_fire = bus.imem_resp_valid & (outst_q != '0);
    assign pop       = buf_vld & bus.instr_ready;

    assign bus.imem_req_valid   = req_vld_q;
    assign bus.imem_req_address = pc_q;
    assign bus.instr_valid      = buf_vld;
    assign bus.instr_data       = buf_vld ? buf_dat_q[rd_ptr_q] : '0;
    assign bus.instr_pc         = buf_vld ? buf_pc_q[rd_ptr_q]  : '0;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        resp_pc_d = resp_pc_q;
        discard_d = discard_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        push      = 1'b0;
        outst_d   = outst_q + CW'(req_fire) - CW'(resp_fire);
        case (state_q)
            S_BOOT: begin
                state_d = S_FETCH;
                if (bus.redirect_valid) begin
                    pc_d      = redir_pc;
                    resp_pc_d = redir_pc;
                end
            end
            S_FETCH: begin
                if (bus.redirect_valid) begin
                    // Everything still in flight (including this cycle's request) belongs to the old path.
                    pc_d      = redir_pc;
                    resp_pc_d = redir_pc;
                    count_d   = '0;
                    rd_ptr_d  = '0;
                    wr_ptr_d  = '0;
                    discard_d = outst_d;
                    state_d   = (outst_d == '0) ? S_FETCH : S_FLUSH;
                end else begin
                    if (req_fire) pc_d = pc_q + XLEN'(4);
                    if (resp_fire) begin
                        push      = 1'b1;
                        resp_pc_d = resp_pc_q + XLEN'(4);
                        wr_ptr_d  = wr_ptr_q + PW'(1);
                    end
                    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
                    count_d = count_q + CW'(push) - CW'(pop);
                end
            end
            S_FLUSH: begin
                if (resp_fire && discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                    if (discard_q == CW'(1)) state_d = S_FETCH;
                end
                if (bus.redirect_valid) begin
                    pc_d      = redir_pc;
                    resp_pc_d = redir_pc;
                end
            end
            default: state_d = S_BOOT;
        endcase
        // Registered request valid: evaluated on next-state credits so it matches the live credit count.
        req_vld_d = (state_d == S_FETCH) && (({1'b0, outst_d} + {1'b0, count_d}) < DEPTH_L);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_VECTOR;
            resp_pc_q <= RESET_VECTOR;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            req_vld_q <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_dat_q[i] <= '0;
                buf_pc_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            resp_pc_q <= resp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            req_vld_q <= req_vld_d;
            if (push) begin
                buf_dat_q[wr_ptr_q] <= bus.imem_resp_data;
                buf_pc_q[wr_ptr_q]  <= resp_pc_q;
            end
        end
    end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Purpose: directed self-checking bench for fetch_pc_unit with a fixed-latency in-order imem model.
// Latency: imem answers k cycles after acceptance (k = lat).
// Backpressure: imem_req_ready held high; instr_ready driven per test.
module tb_fetch_pc_unit;
    localparam int          XLEN  = 64;
    localparam int          ILEN  = 32;
    localparam int          DEPTH = 2;
    localparam logic [63:0] RV    = 64'h1000;
    localparam logic [31:0] KEY   = 32'h5A5A_0013;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fetch_pc_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();

    fetch_pc_unit #(
        .XLEN(XLEN), .ILEN(ILEN), .RESET_VECTOR(RV), .BUF_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk    = 0;
    int n_pass   = 0;
    int edge_cnt = 0;
    int lat      = 1;

    mreq_t       mq[$];
    logic [63:0] req_log[$];
    int          req_edge[$];
    logic [63:0] ins_pc[$];
    logic [31:0] ins_dat[$];
    int          ins_edge[$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic bit seq_ok(input logic [63:0] q[$], input logic [63:0] base, input int min_n);
        bit ok = (q.size() >= min_n);
        for (int i = 0; i < q.size(); i++)
            if (q[i] !== base + 64'(4 * i)) ok = 1'b0;
        return ok;
    endfunction

    function automatic bit dat_ok();
        bit ok = (ins_pc.size() > 0);
        for (int i = 0; i < ins_pc.size(); i++)
            if (ins_dat[i] !== (ins_pc[i][31:0] ^ KEY)) ok = 1'b0;
        return ok;
    endfunction

    // Monitor + imem request capture, sampled mid-cycle.
    initial begin
        mreq_t r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
            end else begin
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    r.addr = bus.imem_req_address;
                    r.due  = edge_cnt + 1 + lat;
                    mq.push_back(r);
                    req_log.push_back(bus.imem_req_address);
                    req_edge.push_back(edge_cnt + 1);
                end
                if (bus.instr_valid && bus.instr_ready) begin
                    ins_pc.push_back(bus.instr_pc);
                    ins_dat.push_back(bus.instr_data);
                    ins_edge.push_back(edge_cnt);
                end
            end
        end
    end

    // imem response driver: data is the low address word xor KEY.
    initial begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mq.size() > 0 && mq[0].due == edge_cnt + 1) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mq[0].addr[31:0] ^ KEY;
                void'(mq.pop_front());
            end else begin
                bus.imem_resp_valid = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        req_log.delete();
        req_edge.delete();
        ins_pc.delete();
        ins_dat.delete();
        ins_edge.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_reqs(input string tag, input int n, input int budget);
        int k = 0;
        while (req_log.size() < n && k < budget) begin
            cyc(1);
            k++;
        end
        check(tag, 64'(req_log.size() >= n), 64'd1);
    endtask

    task automatic redirect(input logic [63:0] a);
        bus.redirect_valid   = 1'b1;
        bus.redirect_address = a;
        cyc(1);
        bus.redirect_valid   = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.redirect_valid   = 1'b0;
        bus.redirect_address = '0;
        bus.imem_req_ready   = 1'b1;
        bus.instr_ready      = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("rst_req_addr",  bus.imem_req_address, 64'h1000);
        check("rst_instr_valid", 64'(bus.instr_valid), 64'd0);
        check("rst_instr_data", 64'(bus.instr_data), 64'd0);
        check("rst_instr_pc", bus.instr_pc, 64'd0);

        // Test 1: streaming with 1-cycle imem.
        cyc(1);
        rst_n = 1'b1;
        clear_logs();
        check("boot_no_req", 64'(bus.imem_req_valid), 64'd0);
        cyc(1);
        check("t1_first_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("t1_first_req_addr", bus.imem_req_address, 64'h1000);
        cyc(20);
        check("t1_req0", req_log[0], 64'h1000);
        check("t1_req1", req_log[1], 64'h1004);
        check("t1_req2", req_log[2], 64'h1008);
        check("t1_ins_pc0", ins_pc[0], 64'h1000);
        check("t1_ins_dat0", 64'(ins_dat[0]), 64'h5A5A_1013);
        check("t1_latency", 64'(ins_edge[0] - req_edge[0]), 64'd1);
        check("t1_ins_seq", 64'(seq_ok(ins_pc, 64'h1000, 10)), 64'd1);
        check("t1_req_seq", 64'(seq_ok(req_log, 64'h1000, 10)), 64'd1);
        check("t1_data", 64'(dat_ok()), 64'd1);

        // Test 2: decode stalled from reset -> exactly DEPTH requests.
        bus.instr_ready = 1'b0;
        do_reset();
        cyc(10);
        check("t2_nreq", 64'(req_log.size()), 64'd2);
        check("t2_req_valid_off", 64'(bus.imem_req_valid), 64'd0);
        check("t2_instr_valid", 64'(bus.instr_valid), 64'd1);
        check("t2_hold_pc", bus.instr_pc, 64'h1000);
        check("t2_hold_dat", 64'(bus.instr_data), 64'h5A5A_1013);
        bus.instr_ready = 1'b1;
        cyc(20);
        check("t2_ins_seq", 64'(seq_ok(ins_pc, 64'h1000, 10)), 64'd1);
        check("t2_req_seq", 64'(seq_ok(req_log, 64'h1000, 10)), 64'd1);

        // Test 3: redirect with two fetches outstanding on a 3-cycle imem.
        lat = 3;
        do_reset();
        wait_reqs("t3_wait_reqs", 2, 20);
        redirect(64'h2000);
        check("t3_valid_after_redir", 64'(bus.instr_valid), 64'd0);
        check("t3_flush_no_req", 64'(bus.imem_req_valid), 64'd0);
        clear_logs();
        cyc(25);
        check("t3_first_pc", ins_pc[0], 64'h2000);
        check("t3_first_req", req_log[0], 64'h2000);
        check("t3_ins_seq", 64'(seq_ok(ins_pc, 64'h2000, 5)), 64'd1);
        check("t3_data", 64'(dat_ok()), 64'd1);

        // Test 4: second redirect while flushing; low address bits dropped.
        do_reset();
        wait_reqs("t4_wait_reqs", 2, 20);
        bus.redirect_valid   = 1'b1;
        bus.redirect_address = 64'h3000;
        cyc(1);
        check("t4_flush_no_req", 64'(bus.imem_req_valid), 64'd0);
        bus.redirect_address = 64'h2006;
        cyc(1);
        bus.redirect_valid = 1'b0;
        clear_logs();
        cyc(25);
        check("t4_first_pc", ins_pc[0], 64'h2004);
        check("t4_first_req", req_log[0], 64'h2004);
        check("t4_ins_seq", 64'(seq_ok(ins_pc, 64'h2004, 5)), 64'd1);

        // Test 5: PC wraps at the top of the address space.
        lat = 1;
        do_reset();
        cyc(3);
        redirect(64'hFFFF_FFFF_FFFF_FFFC);
        clear_logs();
        cyc(15);
        check("t5_req0", req_log[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_req1", req_log[1], 64'h0);
        check("t5_ins0", ins_pc[0], 64'hFFFF_FFFF_FFFF_FFFC);
        check("t5_ins1", ins_pc[1], 64'h0);
        check("t5_ins_seq", 64'(seq_ok(ins_pc, 64'hFFFF_FFFF_FFFF_FFFC, 5)), 64'd1);

        // Test 6: asynchronous reset with a full buffer.
        bus.instr_ready = 1'b0;
        do_reset();
        cyc(8);
        check("t6_full_valid", 64'(bus.instr_valid), 64'd1);
        check("t6_full_addr", bus.imem_req_address, 64'h1008);
        #2 rst_n = 1'b0;
        #1;
        check("t6_arst_instr_valid", 64'(bus.instr_valid), 64'd0);
        check("t6_arst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("t6_arst_addr", bus.imem_req_address, 64'h1000);
        check("t6_arst_pc", bus.instr_pc, 64'd0);
        cyc(1);
        rst_n = 1'b1;
        bus.instr_ready = 1'b1;
        clear_logs();
        check("t6_boot_no_req", 64'(bus.imem_req_valid), 64'd0);
        cyc(1);
        check("t6_restart_valid", 64'(bus.imem_req_valid), 64'd1);
        check("t6_restart_addr", bus.imem_req_address, 64'h1000);
        cyc(15);
        check("t6_ins_seq", 64'(seq_ok(ins_pc, 64'h1000, 5)), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
